// File: rtl/ahbl_resp_ram.sv
// ahbl_resp_ram: AHB-Lite slave RAM of 2^AWIDTH 32-bit words with WAIT_CYCLES wait states per transfer.
// Define AHBL_RESP_RAM_ERR_EN to answer oversized or unaligned transfers with a two-cycle ERROR response.
module ahbl_resp_ram #(
    parameter int AWIDTH      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic        HMASTLOCK,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int         DEPTH     = 1 << AWIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef AHBL_RESP_RAM_ERR_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_go_state;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_wait_cnt_nxt;
    logic [AWIDTH+1:0] r_addr;
    logic              r_write;
    logic [2:0]        r_size;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_load;
    logic              w_we;
    logic [3:0]        w_be;
    logic [AWIDTH-1:0] w_word;
    logic              w_unused;

    // Upper address bits alias onto the low window; burst/protection info is not needed.
    assign w_unused = ^{HBURST, HMASTLOCK, HPROT, HTRANS[0], HADDR[31:AWIDTH+2]};

    assign w_accept = HSEL & HREADYIN & HTRANS[1];
    assign w_load   = HREADYOUT & w_accept;
    assign w_word   = r_addr[AWIDTH+1:2];

    // Destination of a freshly accepted transfer.
    always_comb begin
        w_go_state = (WAIT_CYCLES > 0) ? S_WAIT : S_DATA;
`ifdef AHBL_RESP_RAM_ERR_EN
        if ((HSIZE > 3'd2) ||
            ((HSIZE == 3'd1) && HADDR[0]) ||
            ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))) begin
            w_go_state = S_ERR1;
        end
`endif
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        HREADYOUT      = 1'b1;
        HRESP          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_go_state;
                end
            end
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            S_DATA: begin
                w_state_nxt = w_accept ? w_go_state : S_IDLE;
            end
`ifdef AHBL_RESP_RAM_ERR_EN
            S_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 1'b1;
                w_state_nxt = S_ERR2;
            end
            S_ERR2: begin
                HRESP       = 1'b1;
                w_state_nxt = w_accept ? w_go_state : S_IDLE;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // The counter is loaded on entry so WAIT lasts exactly WAIT_CYCLES cycles.
        if ((w_state_nxt == S_WAIT) && (r_state != S_WAIT)) begin
            w_wait_cnt_nxt = WAIT_LOAD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
        end else if (w_load) begin
            r_addr  <= HADDR[AWIDTH+1:0];
            r_write <= HWRITE;
            r_size  <= HSIZE;
        end
    end

    // Lane selection; oversized transfers act as words and low bits are masked to natural alignment.
    always_comb begin
        w_be = 4'b0000;
        if (r_size[2] | r_size[1]) begin
            w_be = 4'b1111;
        end else if (r_size[0]) begin
            w_be = r_addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            w_be = 4'b0001 << r_addr[1:0];
        end
    end

    // A reset arriving in the data phase drops the pending write.
    assign w_we = (r_state == S_DATA) & r_write & HRESETN;

    // NOTE: the storage array has no reset; contents survive HRESETN and it maps onto plain RAM.
    always_ff @(posedge HCLK) begin
        if (w_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_word][8*k +: 8] <= HWDATA[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        HRDATA = 32'h0000_0000;
        if ((r_state == S_DATA) && !r_write) begin
            HRDATA = r_mem[w_word];
        end
    end

endmodule
